// File: rtl/store_queue_if.sv
// store_queue_if: AGU enqueue, ROB commit/flush, load conflict probe and memory drain port
interface store_queue_if;
    logic        flush_i;
    logic        enqueue_en_i;
    logic [29:0] enqueue_address_i;
    logic [31:0] enqueue_data_i;
    logic [3:0]  enqueue_bm_i;
    logic        enqueue_io_i;
    logic [4:0]  enqueue_rob_i;
    logic        enqueue_full_o;
    logic        commit_i;
    logic [29:0] conflict_address_i;
    logic [3:0]  conflict_bm_i;
    logic        conflict_o;
    logic        mem_req_o;
    logic [29:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [3:0]  mem_bm_o;
    logic        mem_io_o;
    logic [4:0]  mem_rob_o;
    logic        mem_ack_i;
    logic        empty_o;

    modport master (
        output flush_i, enqueue_en_i, enqueue_address_i, enqueue_data_i, enqueue_bm_i,
               enqueue_io_i, enqueue_rob_i, commit_i, conflict_address_i, conflict_bm_i, mem_ack_i,
        input  enqueue_full_o, conflict_o, mem_req_o, mem_addr_o, mem_data_o, mem_bm_o,
               mem_io_o, mem_rob_o, empty_o
    );

    modport slave (
        input  flush_i, enqueue_en_i, enqueue_address_i, enqueue_data_i, enqueue_bm_i,
               enqueue_io_i, enqueue_rob_i, commit_i, conflict_address_i, conflict_bm_i, mem_ack_i,
        output enqueue_full_o, conflict_o, mem_req_o, mem_addr_o, mem_data_o, mem_bm_o,
               mem_io_o, mem_rob_o, empty_o
    );
endinterface

// File: rtl/store_queue.sv
// store_queue: in-order store buffer holding stores until commit, draining committed ones to memory
module store_queue #(
    parameter int DEPTH = 8
) (
    input logic          cpu_clock_i,
    input logic          cpu_reset_i,
    store_queue_if.slave sq
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    typedef enum logic {IDLE, REQ} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] head_q, head_d, commit_q, commit_d, tail_q, tail_d, count;
    logic [29:0]   addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [3:0]    bm_q   [DEPTH];
    logic          io_q   [DEPTH];
    logic [4:0]    rob_q  [DEPTH];
    logic [DEPTH-1:0] valid;
    logic          full, enq, conflict;
    logic          mem_req_q, mem_req_d, mem_io_q, mem_io_d;
    logic [29:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_data_q, mem_data_d;
    logic [3:0]    mem_bm_q, mem_bm_d;
    logic [4:0]    mem_rob_q, mem_rob_d;
    logic [IW-1:0] hidx;

    // Pointer bookkeeping: a flush rewinds tail to the commit point after any same-cycle commit
    always_comb begin
        count    = tail_q - head_q;
        full     = count == PW'(DEPTH);
        enq      = sq.enqueue_en_i && !full && !sq.flush_i;
        commit_d = commit_q + PW'(sq.commit_i && commit_q != tail_q);
        tail_d   = sq.flush_i ? commit_d : tail_q + PW'(enq);
    end

    // Drain FSM: latch the oldest committed entry onto the memory port and hold it until acked
    always_comb begin
        hidx       = head_q[IW-1:0];
        state_d    = state_q;
        head_d     = head_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_bm_d   = mem_bm_q;
        mem_io_d   = mem_io_q;
        mem_rob_d  = mem_rob_q;
        if (state_q == IDLE && head_q != commit_q) begin
            mem_req_d  = 1'b1;
            mem_addr_d = addr_q[hidx];
            mem_data_d = data_q[hidx];
            mem_bm_d   = bm_q[hidx];
            mem_io_d   = io_q[hidx];
            mem_rob_d  = rob_q[hidx];
            state_d    = REQ;
        end else if (state_q == REQ && sq.mem_ack_i) begin
            head_d    = head_q + PW'(1);
            mem_req_d = 1'b0;
            state_d   = IDLE;
        end
    end

    // Load conflict probe over every occupied slot, including the one currently draining
    always_comb begin
        valid    = '0;
        conflict = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            valid[i] = {1'b0, IW'(i) - head_q[IW-1:0]} < count;
            conflict = conflict || (valid[i] && addr_q[i] == sq.conflict_address_i &&
                                    |(bm_q[i] & sq.conflict_bm_i));
        end
    end

    // Control state; asynchronous reset abandons any in-flight drain request
    always_ff @(posedge cpu_clock_i or posedge cpu_reset_i) begin
        if (cpu_reset_i) begin
            state_q    <= IDLE;
            head_q     <= '0;
            commit_q   <= '0;
            tail_q     <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_bm_q   <= '0;
            mem_io_q   <= 1'b0;
            mem_rob_q  <= '0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            commit_q   <= commit_d;
            tail_q     <= tail_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            mem_bm_q   <= mem_bm_d;
            mem_io_q   <= mem_io_d;
            mem_rob_q  <= mem_rob_d;
        end
    end

    // Entry payload storage; occupancy comes from the pointers so no reset is needed here
    always_ff @(posedge cpu_clock_i) begin
        if (enq) begin
            addr_q[tail_q[IW-1:0]] <= sq.enqueue_address_i;
            data_q[tail_q[IW-1:0]] <= sq.enqueue_data_i;
            bm_q[tail_q[IW-1:0]]   <= sq.enqueue_bm_i;
            io_q[tail_q[IW-1:0]]   <= sq.enqueue_io_i;
            rob_q[tail_q[IW-1:0]]  <= sq.enqueue_rob_i;
        end
    end

    assign sq.enqueue_full_o = full;
    assign sq.conflict_o     = conflict;
    assign sq.mem_req_o      = mem_req_q;
    assign sq.mem_addr_o     = mem_addr_q;
    assign sq.mem_data_o     = mem_data_q;
    assign sq.mem_bm_o       = mem_bm_q;
    assign sq.mem_io_o       = mem_io_q;
    assign sq.mem_rob_o      = mem_rob_q;
    assign sq.empty_o        = head_q == tail_q && state_q == IDLE;
endmodule

// File: tb/tb_store_queue.sv
// tb_store_queue: directed and table-driven checks of the store queue
module tb_store_queue;
    logic clk, rst;
    int checks = 0;
    int errors = 0;

    store_queue_if sq();

    store_queue #(.DEPTH(8)) dut (
        .cpu_clock_i(clk),
        .cpu_reset_i(rst),
        .sq(sq)
    );

    typedef struct {
        logic [29:0] a;
        logic [3:0]  bm;
        logic        exp;
    } cvec_t;

    cvec_t cv [8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] dat(input logic [29:0] a);
        return {2'b00, a} ^ 32'h5A5A_0000;
    endfunction

    task automatic enq(input logic [29:0] a, input logic [3:0] bm, input logic io);
        sq.enqueue_en_i      = 1'b1;
        sq.enqueue_address_i = a;
        sq.enqueue_data_i    = dat(a);
        sq.enqueue_bm_i      = bm;
        sq.enqueue_io_i      = io;
        sq.enqueue_rob_i     = a[4:0];
        step();
        sq.enqueue_en_i = 1'b0;
    endtask

    task automatic commit_n(input int n);
        sq.commit_i = 1'b1;
        repeat (n) step();
        sq.commit_i = 1'b0;
    endtask

    task automatic probe(input logic [29:0] a, input logic [3:0] bm, input logic exp, input string nm);
        sq.conflict_address_i = a;
        sq.conflict_bm_i      = bm;
        #1;
        chk(nm, 64'(sq.conflict_o), 64'(exp));
    endtask

    task automatic drain_expect(input logic [29:0] a, input logic [3:0] bm, input logic io);
        int n = 0;
        while (!sq.mem_req_o && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (!sq.mem_req_o) begin
            errors++;
            $display("FAIL drain_timeout: no mem_req_o for addr %0h within 20 cycles", a);
        end else begin
            chk("drain_addr", 64'(sq.mem_addr_o), 64'(a));
            chk("drain_data", 64'(sq.mem_data_o), 64'(dat(a)));
            chk("drain_bm", 64'(sq.mem_bm_o), 64'(bm));
            chk("drain_io", 64'(sq.mem_io_o), 64'(io));
            chk("drain_rob", 64'(sq.mem_rob_o), 64'(a[4:0]));
            sq.mem_ack_i = 1'b1;
            step();
            sq.mem_ack_i = 1'b0;
            chk("drain_req_drop", 64'(sq.mem_req_o), 64'd0);
        end
    endtask

    initial begin
        cv[0] = '{30'h40, 4'b0011, 1'b0};
        cv[1] = '{30'h40, 4'b0100, 1'b1};
        cv[2] = '{30'h41, 4'b1111, 1'b0};
        cv[3] = '{30'h40, 4'b1000, 1'b1};
        cv[4] = '{30'h50, 4'b0001, 1'b1};
        cv[5] = '{30'h50, 4'b0010, 1'b0};
        cv[6] = '{30'h40, 4'b0000, 1'b0};
        cv[7] = '{30'h3F, 4'b1111, 1'b0};

        rst = 1'b1;
        sq.flush_i = 1'b0;
        sq.enqueue_en_i = 1'b0;
        sq.enqueue_address_i = '0;
        sq.enqueue_data_i = '0;
        sq.enqueue_bm_i = '0;
        sq.enqueue_io_i = 1'b0;
        sq.enqueue_rob_i = '0;
        sq.commit_i = 1'b0;
        sq.conflict_address_i = '0;
        sq.conflict_bm_i = '0;
        sq.mem_ack_i = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        chk("rst_req", 64'(sq.mem_req_o), 64'd0);
        chk("rst_full", 64'(sq.enqueue_full_o), 64'd0);
        chk("rst_empty", 64'(sq.empty_o), 64'd1);
        chk("rst_addr", 64'(sq.mem_addr_o), 64'd0);
        chk("rst_data", 64'(sq.mem_data_o), 64'd0);
        chk("rst_bm", 64'(sq.mem_bm_o), 64'd0);

        // Single store: request two cycles after enqueue, held stable while unacked
        enq(30'h100, 4'b0001, 1'b1);
        chk("t1_empty_after_enq", 64'(sq.empty_o), 64'd0);
        commit_n(1);
        chk("t1_req_early", 64'(sq.mem_req_o), 64'd0);
        step();
        chk("t1_req", 64'(sq.mem_req_o), 64'd1);
        chk("t1_addr", 64'(sq.mem_addr_o), 64'h100);
        chk("t1_bm", 64'(sq.mem_bm_o), 64'b0001);
        chk("t1_io", 64'(sq.mem_io_o), 64'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t1_hold_req", 64'(sq.mem_req_o), 64'd1);
            chk("t1_hold_addr", 64'(sq.mem_addr_o), 64'h100);
            chk("t1_hold_data", 64'(sq.mem_data_o), 64'(dat(30'h100)));
            probe(30'h100, 4'b0001, 1'b1, "t1_hold_head");
        end
        sq.mem_ack_i = 1'b1;
        step();
        sq.mem_ack_i = 1'b0;
        chk("t1_req_after_ack", 64'(sq.mem_req_o), 64'd0);
        chk("t1_empty_after_ack", 64'(sq.empty_o), 64'd1);
        probe(30'h100, 4'b0001, 1'b0, "t1_conflict_gone");

        // Conflict table against two uncommitted stores
        enq(30'h40, 4'b1100, 1'b0);
        enq(30'h50, 4'b0001, 1'b0);
        for (int i = 0; i < 8; i++) probe(cv[i].a, cv[i].bm, cv[i].exp, $sformatf("conflict_vec%0d", i));
        sq.enqueue_en_i      = 1'b1;
        sq.enqueue_address_i = 30'h60;
        sq.enqueue_bm_i      = 4'b1111;
        probe(30'h60, 4'b1111, 1'b0, "conflict_same_cycle_enq");
        step();
        sq.enqueue_en_i = 1'b0;
        probe(30'h60, 4'b1111, 1'b1, "conflict_after_enq");
        sq.flush_i = 1'b1;
        step();
        sq.flush_i = 1'b0;
        probe(30'h40, 4'b1111, 1'b0, "flush_all_conflict");
        chk("flush_all_empty", 64'(sq.empty_o), 64'd1);
        sq.flush_i = 1'b1;
        enq(30'h70, 4'b1111, 1'b0);
        sq.flush_i = 1'b0;
        probe(30'h70, 4'b1111, 1'b0, "flush_drops_enq");
        chk("flush_drops_enq_empty", 64'(sq.empty_o), 64'd1);

        // Flush with one committed entry: only it drains
        enq(30'h300, 4'b1111, 1'b0);
        enq(30'h301, 4'b1111, 1'b0);
        enq(30'h302, 4'b1111, 1'b0);
        commit_n(1);
        sq.flush_i = 1'b1;
        step();
        sq.flush_i = 1'b0;
        probe(30'h301, 4'b1111, 1'b0, "t3_flushed_301");
        probe(30'h302, 4'b1111, 1'b0, "t3_flushed_302");
        probe(30'h300, 4'b1111, 1'b1, "t3_committed_kept");
        drain_expect(30'h300, 4'b1111, 1'b0);
        chk("t3_empty", 64'(sq.empty_o), 64'd1);
        repeat (3) step();
        chk("t3_no_more_req", 64'(sq.mem_req_o), 64'd0);

        // Fill to DEPTH, hold ninth store until first drain frees a slot
        for (int i = 0; i < 8; i++) enq(30'h200 + 30'(i), 4'b0011, 1'b0);
        chk("t2_full", 64'(sq.enqueue_full_o), 64'd1);
        sq.enqueue_en_i      = 1'b1;
        sq.enqueue_address_i = 30'h208;
        sq.enqueue_data_i    = dat(30'h208);
        sq.enqueue_bm_i      = 4'b0011;
        sq.enqueue_io_i      = 1'b0;
        sq.enqueue_rob_i     = 5'h08;
        step();
        step();
        chk("t2_full_held", 64'(sq.enqueue_full_o), 64'd1);
        commit_n(8);
        chk("t2_req", 64'(sq.mem_req_o), 64'd1);
        chk("t2_addr", 64'(sq.mem_addr_o), 64'h200);
        chk("t2_full_before_ack", 64'(sq.enqueue_full_o), 64'd1);
        sq.mem_ack_i = 1'b1;
        step();
        sq.mem_ack_i = 1'b0;
        chk("t2_space_after_ack", 64'(sq.enqueue_full_o), 64'd0);
        step();
        sq.enqueue_en_i = 1'b0;
        chk("t2_ninth_accepted", 64'(sq.enqueue_full_o), 64'd1);
        commit_n(1);
        for (int i = 1; i < 9; i++) drain_expect(30'h200 + 30'(i), 4'b0011, 1'b0);
        chk("t2_empty", 64'(sq.empty_o), 64'd1);

        // Pointer wrap: many single round trips, then a full queue straddling the wrap point
        for (int k = 0; k < 20; k++) begin
            enq(30'h500 + 30'(k), 4'(k + 1), k[0]);
            commit_n(1);
            drain_expect(30'h500 + 30'(k), 4'(k + 1), k[0]);
            chk("t6_empty", 64'(sq.empty_o), 64'd1);
        end
        for (int i = 0; i < 8; i++) enq(30'h600 + 30'(i), 4'b1010, 1'b0);
        chk("t6_full_wrap", 64'(sq.enqueue_full_o), 64'd1);
        commit_n(8);
        for (int i = 0; i < 8; i++) drain_expect(30'h600 + 30'(i), 4'b1010, 1'b0);
        chk("t6_empty_wrap", 64'(sq.empty_o), 64'd1);
        chk("t6_not_full", 64'(sq.enqueue_full_o), 64'd0);

        // Asynchronous reset in the middle of a request
        enq(30'h700, 4'b1111, 1'b0);
        commit_n(1);
        step();
        chk("t5_req", 64'(sq.mem_req_o), 64'd1);
        #3 rst = 1'b1;
        #1;
        chk("t5_rst_req", 64'(sq.mem_req_o), 64'd0);
        chk("t5_rst_empty", 64'(sq.empty_o), 64'd1);
        chk("t5_rst_addr", 64'(sq.mem_addr_o), 64'd0);
        step();
        rst = 1'b0;
        step();
        chk("t5_post_req", 64'(sq.mem_req_o), 64'd0);
        chk("t5_post_empty", 64'(sq.empty_o), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
